multicycle_ctrl: RTL

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It uses the opcode produced by the decode stage and handshakes with instruction and data memory. From these it generates every PC, IR, register-file, ALU-mux and memory strobe for the shared single-ALU datapath. It sits between the decoder and the datapath and is the only writer of architectural state enables.

---
 rtl/multicycle_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-ALU RV32I datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap unrecognised opcodes instead of executing them as FENCE.
module multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic [1:0] alu_op_sel,
   output logic       retired,
   output logic       halted,
   output logic [1:0] trap_cause,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_OP, C_OPIMM, C_LUI, C_AUIPC, C_LOAD, C_STORE,
      C_BRANCH, C_JAL, C_JALR, C_FENCE, C_SYSTEM, C_ILL
   } cls_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state, state_nxt;
   cls_t       cls, cls_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [1:0] cause, cause_nxt;

   function automatic cls_t classify(input logic [6:0] op);
      case (op)
         7'b0110011: classify = C_OP;
         7'b0010011: classify = C_OPIMM;
         7'b0110111: classify = C_LUI;
         7'b0010111: classify = C_AUIPC;
         7'b0000011: classify = C_LOAD;
         7'b0100011: classify = C_STORE;
         7'b1100011: classify = C_BRANCH;
         7'b1101111: classify = C_JAL;
         7'b1100111: classify = C_JALR;
         7'b0001111: classify = C_FENCE;
         7'b1110011: classify = C_SYSTEM;
         default:    classify = C_ILL;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
         cls   <= C_OP;
         cnt   <= '0;
         cause <= '0;
      end else begin
         state <= state_nxt;
         cls   <= cls_nxt;
         cnt   <= cnt_nxt;
         cause <= cause_nxt;
      end
   end

   assign state_dbg  = state;
   assign trap_cause = cause;

   // Everything is held at zero while rst_n is low, so an aborted access leaves no stray strobe.
   always_comb begin
      state_nxt  = state;
      cls_nxt    = cls;
      cnt_nxt    = '0;
      cause_nxt  = cause;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'd0;
      reg_we     = 1'b0;
      wb_sel     = 2'd0;
      alu_a_sel  = 1'b0;
      alu_b_sel  = 1'b0;
      alu_op_sel = 2'd0;
      retired    = 1'b0;
      halted     = 1'b0;
      if (rst_n) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we     = 1'b1;
                  state_nxt = S_DECODE;
               end else begin
                  cnt_nxt = cnt + 8'd1;
                  if (cnt == TMO_LAST) begin
                     state_nxt = S_TRAP;
                     cause_nxt = 2'd2;
                  end
               end
            end
            S_DECODE: begin
               cls_nxt   = classify(opcode);
               state_nxt = S_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
               if (classify(opcode) == C_ILL) begin
                  state_nxt = S_TRAP;
                  cause_nxt = 2'd1;
               end
`endif
            end
            S_EXEC: begin
               state_nxt = S_WB;
               case (cls)
                  C_OP:    alu_op_sel = 2'd1;
                  C_OPIMM: begin
                     alu_op_sel = 2'd1;
                     alu_b_sel  = 1'b1;
                  end
                  C_LUI:   alu_b_sel = 1'b1;
                  C_AUIPC: begin
                     alu_a_sel = 1'b1;
                     alu_b_sel = 1'b1;
                  end
                  C_LOAD, C_STORE: begin
                     alu_b_sel = 1'b1;
                     state_nxt = S_MEM;
                  end
                  C_BRANCH: begin
                     alu_op_sel = 2'd2;
                     pc_we      = 1'b1;
                     pc_sel     = branch_taken ? 2'd1 : 2'd0;
                     retired    = 1'b1;
                     state_nxt  = S_FETCH;
                  end
                  C_JAL, C_JALR: state_nxt = S_WB;
                  C_SYSTEM: begin
                     state_nxt = S_TRAP;
                     cause_nxt = 2'd3;
                  end
                  default: begin
                     pc_we     = 1'b1;
                     retired   = 1'b1;
                     state_nxt = S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (cls == C_STORE);
               if (dmem_ready) begin
                  if (cls == C_STORE) begin
                     pc_we     = 1'b1;
                     retired   = 1'b1;
                     state_nxt = S_FETCH;
                  end else begin
                     state_nxt = S_WB;
                  end
               end else begin
                  cnt_nxt = cnt + 8'd1;
                  if (cnt == TMO_LAST) begin
                     state_nxt = S_TRAP;
                     cause_nxt = 2'd2;
                  end
               end
            end
            S_WB: begin
               reg_we    = 1'b1;
               pc_we     = 1'b1;
               retired   = 1'b1;
               wb_sel    = (cls == C_LOAD) ? 2'd1 :
                           (cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0;
               pc_sel    = (cls == C_JAL) ? 2'd1 : (cls == C_JALR) ? 2'd2 : 2'd0;
               state_nxt = S_FETCH;
            end
            S_TRAP: halted = 1'b1;
            default: state_nxt = S_FETCH;
         endcase
      end
   end

endmodule
